// File: rtl/ins_encoder_loader.sv
// rtl/ins_encoder_loader.sv - MIPS instruction encoder with FIFO-buffered IMEM write loader
//
// Packs decoded instruction fields into 32-bit MIPS words, queues them in a
// DEPTH-entry FIFO and writes them to instruction memory at consecutive word
// addresses starting at BASE_ADDR.
//
// Optional build macro: INS_ENC_CHECK_EN
//   When defined, the encoder also rejects the following tuples (dropped, err set):
//   - R-format with a non-zero op
//   - I-format with op outside {4,5,8..15,35,43}
//   - J-format with op outside {2,3}
//   - JR (func=8) with non-zero rd/rt/shamt
//   When undefined, only fmt=3 is rejected.
//
// Ports:
//   CLK, RST         clock, synchronous active-low reset
//   in_valid/ready   field-tuple handshake
//   fmt, op, rs, rt, rd, shamt, func, imm16, target26   decoded fields
//   flush            stop accepting, drain FIFO, pulse done
//   addr_clr         reload write address to BASE_ADDR (IDLE/RUN, FIFO empty)
//   im_we/im_ready   IMEM write handshake
//   im_addr/im_wdata IMEM write address / data
//   wr_count         saturating count of words written
//   done             one-cycle pulse at end of drain
//   err              sticky illegal-tuple flag
module ins_encoder_loader #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        func,
    input  logic [15:0]       imm16,
    input  logic [25:0]       target26,
    input  logic              flush,
    input  logic              addr_clr,
    output logic              im_we,
    input  logic              im_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [15:0]       wr_count,
    output logic              done,
    output logic              err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [31:0]       r_mem [DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_hold;
    logic [15:0]       r_wr_count;
    logic              r_done;
    logic              r_err;

    logic              w_empty;
    logic              w_full;
    logic              w_accepting;
    logic              w_push;
    logic              w_pop;
    logic              w_legal;
    logic [31:0]       w_enc;
    logic [31:0]       w_head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                         (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_accepting = (r_state == S_IDLE) || (r_state == S_RUN);
    assign w_head      = r_mem[r_rd_ptr[PTR_W-1:0]];

    assign in_ready = !w_full && w_accepting;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_empty && im_ready;

    assign im_we    = !w_empty;
    // When empty, present the last word written so im_wdata holds steady.
    assign im_wdata = w_empty ? r_hold : w_head;
    assign im_addr  = r_addr;
    assign wr_count = r_wr_count;
    assign done     = r_done;
    assign err      = r_err;

    always_comb begin
        w_enc = 32'd0;
        case (fmt)
            2'd0:    w_enc = {6'd0, rs, rt, rd, shamt, func};
            2'd1:    w_enc = {op, rs, rt, imm16};
            2'd2:    w_enc = {op, target26};
            default: w_enc = 32'd0;
        endcase
    end

`ifdef INS_ENC_CHECK_EN
    always_comb begin
        w_legal = 1'b0;
        case (fmt)
            2'd0: w_legal = (op == 6'd0) &&
                            !((func == 6'd8) && ((rd != 5'd0) || (rt != 5'd0) || (shamt != 5'd0)));
            2'd1: w_legal = (op == 6'd4) || (op == 6'd5) ||
                            ((op >= 6'd8) && (op <= 6'd15)) ||
                            (op == 6'd35) || (op == 6'd43);
            2'd2: w_legal = (op == 6'd2) || (op == 6'd3);
            default: w_legal = 1'b0;
        endcase
    end
`else
    assign w_legal = (fmt != 2'd3);
`endif

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge CLK) begin
        if (w_push && w_legal) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_enc;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_addr     <= BASE_ADDR;
            r_hold     <= 32'd0;
            r_wr_count <= 16'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Illegal tuples complete the handshake but never enter the FIFO.
            if (w_push) begin
                if (w_legal) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end

            // A pop implies non-empty, so it can never collide with addr_clr.
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_addr   <= r_addr + ADDR_W'(4);
                r_hold   <= w_head;
                if (r_wr_count != 16'hFFFF) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end
            end else if (addr_clr && w_accepting && w_empty) begin
                r_addr <= BASE_ADDR;
            end

            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_state <= S_DRAIN;
                    end else if (w_push) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_encoder_loader.sv
// tb/tb_ins_encoder_loader.sv - randomized self-checking bench for ins_encoder_loader
module tb_ins_encoder_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  fmt = '0;
    logic [5:0]  op = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  func = '0;
    logic [15:0] imm16 = '0;
    logic [25:0] target26 = '0;
    logic        flush = 1'b0;
    logic        addr_clr = 1'b0;
    logic        im_we;
    logic        im_ready = 1'b0;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic [15:0] wr_count;
    logic        done;
    logic        err;

    ins_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
        .imm16(imm16), .target26(target26),
        .flush(flush), .addr_clr(addr_clr),
        .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
        .wr_count(wr_count), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: queue of pending words, next write address, phase
    // (0 = accepting, 1 = draining, 2 = done pulse).
    logic [31:0] exp_q[$];
    logic [31:0] m_addr;
    logic [31:0] m_last;
    logic [15:0] m_wr;
    logic        m_err;
    int          phase;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_legal(input logic [1:0] f, input int o, input int t,
                                     input int d, input int s, input int fn);
        if (f == 2'd3) return 1'b0;
`ifdef INS_ENC_CHECK_EN
        if (f == 2'd0) return (o == 0) && !(fn == 8 && (d != 0 || t != 0 || s != 0));
        if (f == 2'd1) return o == 4 || o == 5 || (o >= 8 && o <= 15) || o == 35 || o == 43;
        return o == 2 || o == 3;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] ref_encode();
        logic [31:0] w;
        case (fmt)
            2'd0:    w = (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + (32'(shamt) << 6) + 32'(func);
            2'd1:    w = (32'(op) << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm16);
            default: w = (32'(op) << 26) + 32'(target26);
        endcase
        return w;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_addr = BASE;
        m_last = 32'd0;
        m_wr   = 16'd0;
        m_err  = 1'b0;
        phase  = 0;
    endtask

    // Called just after a negedge with inputs set: check outputs, advance model, step one clock.
    task automatic cycle();
        int sz;
        bit exp_ir;
        #1;
        sz     = exp_q.size();
        exp_ir = (phase == 0) && (sz < DEPTH);
        check("in_ready", 64'(in_ready), 64'(exp_ir));
        check("im_we", 64'(im_we), 64'(sz != 0));
        check("im_addr", 64'(im_addr), 64'(m_addr));
        check("im_wdata", 64'(im_wdata), 64'((sz != 0) ? exp_q[0] : m_last));
        check("done", 64'(done), 64'(phase == 2));
        check("err", 64'(err), 64'(m_err));
        check("wr_count", 64'(wr_count), 64'(m_wr));
        if (sz != 0 && im_ready) begin
            m_last = exp_q.pop_front();
            m_addr = m_addr + 32'd4;
            if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
        end
        if (addr_clr && phase == 0 && sz == 0) m_addr = BASE;
        if (in_valid && exp_ir) begin
            if (ref_legal(fmt, int'(op), int'(rt), int'(rd), int'(shamt), int'(func)))
                exp_q.push_back(ref_encode());
            else
                m_err = 1'b1;
        end
        case (phase)
            0:       if (flush) phase = 1;
            1:       if (sz == 0) phase = 2;
            default: phase = 0;
        endcase
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        flush    = 1'b0;
        addr_clr = 1'b0;
    endtask

    task automatic drive(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s_, input logic [4:0] t_,
                         input logic [4:0] d_, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] im, input logic [25:0] tg);
        in_valid = 1'b1;
        fmt = f; op = o; rs = s_; rt = t_; rd = d_; shamt = sh; func = fn; imm16 = im; target26 = tg;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        model_clear();
    endtask

    int n_done;
    logic [15:0] wr_before;

    initial begin
        @(negedge CLK);
        do_reset();
        #1;
        check("rst_im_we", 64'(im_we), 64'd0);
        check("rst_im_addr", 64'(im_addr), 64'(BASE));
        check("rst_im_wdata", 64'(im_wdata), 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        // 1: single R-type word
        im_ready = 1'b1;
        drive(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0);
        cycle();
        idle_inputs();
        #1;
        check("t1_we", 64'(im_we), 64'd1);
        check("t1_data", 64'(im_wdata), 64'h00221820);
        check("t1_addr", 64'(im_addr), 64'h0);
        cycle();
        #1;
        check("t1_count", 64'(wr_count), 64'd1);
        cycle();

        // 2: I then J back-to-back
        do_reset();
        drive(2'd1, 6'd8, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
        cycle();
        drive(2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h100);
        #1;
        check("t2_i_data", 64'(im_wdata), 64'h2005FFFF);
        check("t2_i_addr", 64'(im_addr), 64'h0);
        cycle();
        idle_inputs();
        #1;
        check("t2_j_data", 64'(im_wdata), 64'h0C000100);
        check("t2_j_addr", 64'(im_addr), 64'h4);
        cycle();
        cycle();

        // 3: fill with IMEM stalled, then release
        do_reset();
        im_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(2'd1, 6'd9, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'd0, 16'(i * 3), 26'd0);
            cycle();
        end
        #1;
        check("t3_full", 64'(in_ready), 64'd0);
        cycle();
        idle_inputs();
        im_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        #1;
        check("t3_addr_end", 64'(im_addr), 64'(BASE + 4 * DEPTH));
        check("t3_count", 64'(wr_count), 64'(DEPTH));

        // 4: two words then flush
        im_ready = 1'b0;
        wr_before = wr_count;
        for (int i = 0; i < 2; i++) begin
            drive(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'(i + 7));
            cycle();
        end
        idle_inputs();
        flush = 1'b1;
        im_ready = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        check("t4_blocked", 64'(in_ready), 64'd0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (done) n_done++;
            cycle();
        end
        check("t4_done_cycles", 64'(n_done), 64'd1);
        check("t4_writes", 64'(wr_count - wr_before), 64'd2);
        check("t4_idle_ready", 64'(in_ready), 64'd1);

        // 5: reserved format dropped, err sticky
        drive(2'd3, 6'd8, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1234, 26'd0);
        cycle();
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle();
        #1;
        check("t5_err", 64'(err), 64'd1);
        check("t5_no_write", 64'(im_we), 64'd0);

        // 6: reset with three words held
        im_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(2'd0, 6'd0, 5'(i), 5'd4, 5'd5, 5'd6, 6'h21, 16'd0, 26'd0);
            cycle();
        end
        do_reset();
        #1;
        check("t6_we", 64'(im_we), 64'd0);
        check("t6_addr", 64'(im_addr), 64'(BASE));
        check("t6_count", 64'(wr_count), 64'd0);
        check("t6_err", 64'(err), 64'd0);

`ifdef INS_ENC_CHECK_EN
        im_ready = 1'b1;
        drive(2'd0, 6'd4, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0);
        cycle();
        idle_inputs();
        cycle();
        #1;
        check("t5b_err", 64'(err), 64'd1);
        check("t5b_dropped", 64'(wr_count), 64'd0);
        do_reset();
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            fmt      = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            op       = 6'($urandom);
            rs       = 5'($urandom);
            rt       = 5'($urandom);
            rd       = 5'($urandom);
            shamt    = 5'($urandom);
            func     = 6'($urandom);
            imm16    = 16'($urandom);
            target26 = 26'($urandom);
            im_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 49) == 0);
            addr_clr = ($urandom_range(0, 29) == 0);
            cycle();
        end
        idle_inputs();
        im_ready = 1'b1;
        for (int i = 0; i < DEPTH + 4; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
